// File: rtl/ram36k_pkg.sv
// ram36k_pkg
// Shared geometry and width/lane helpers for the 36Kb true-dual-port RAM.
// The array is ROWS rows of DATA_W data bits plus PAR_W parity bits.
// Every port access decodes its own effective width (1, 2, 4, 9, 18 or 36)
// into a lane offset and a lane mask inside one row.
package ram36k_pkg;

    localparam int ROWS   = 1024;
    localparam int DATA_W = 32;
    localparam int PAR_W  = 4;
    localparam int ADDR_W = 15;
    localparam int ROW_W  = $clog2(ROWS);

    // Round a configured width up to the nearest supported port width.
    function automatic int eff_width(input int w);
        if (w <= 1)       return 1;
        else if (w <= 2)  return 2;
        else if (w <= 4)  return 4;
        else if (w <= 9)  return 9;
        else if (w <= 18) return 18;
        else              return 36;
    endfunction

    // Data bits covered by one access of the given effective width, at offset 0.
    function automatic logic [DATA_W-1:0] data_unit_mask(input int ew);
        logic [DATA_W-1:0] m;
        case (ew)
            1:       m = 32'h0000_0001;
            2:       m = 32'h0000_0003;
            4:       m = 32'h0000_000F;
            9:       m = 32'h0000_00FF;
            18:      m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Parity bits covered by one access; narrow (<9) accesses carry no parity.
    function automatic logic [PAR_W-1:0] par_unit_mask(input int ew);
        logic [PAR_W-1:0] m;
        case (ew)
            9:       m = 4'h1;
            18:      m = 4'h3;
            36:      m = 4'hF;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

    // Bit offset of the addressed lane inside the data row. The low address
    // bits below the lane granularity are don't-care and get cleared here.
    function automatic logic [4:0] data_lane_off(input int ew, input logic [4:0] lo);
        logic [4:0] off;
        case (ew)
            1:       off = lo;
            2:       off = {lo[4:1], 1'b0};
            4:       off = {lo[4:2], 2'b00};
            9:       off = {lo[4:3], 3'b000};
            18:      off = {lo[4], 4'b0000};
            default: off = 5'd0;
        endcase
        return off;
    endfunction

    // Offset of the addressed lane inside the parity nibble.
    function automatic logic [1:0] par_lane_off(input int ew, input logic [4:0] lo);
        logic [1:0] off;
        case (ew)
            9:       off = lo[4:3];
            18:      off = {lo[4], 1'b0};
            default: off = 2'd0;
        endcase
        return off;
    endfunction

    // Spread the four byte enables over the 32 data bits.
    function automatic logic [DATA_W-1:0] byte_expand(input logic [PAR_W-1:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/ram36k_port.sv
// ram36k_port
// Address/width decode for one RAM port. Purely combinational.
//   addr       : bit-granular address, row = addr[14:5]
//   be         : byte enables (lane i of the write unit gated by be[i])
//   wdata/wparity : write payload, right-aligned
//   row_data/row_par : current contents of the addressed row (read side)
//   row        : decoded row index
//   wmask_*    : bits of the row this write touches
//   wvec_*     : write payload shifted into row position
//   rdata/rpar : read lane extracted and right-aligned, unused high bits 0
module ram36k_port
    import ram36k_pkg::*;
#(
    parameter int WRITE_WIDTH = 36,
    parameter int READ_WIDTH  = 36
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [PAR_W-1:0]  be,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PAR_W-1:0]  wparity,
    input  logic [DATA_W-1:0] row_data,
    input  logic [PAR_W-1:0]  row_par,
    output logic [ROW_W-1:0]  row,
    output logic [DATA_W-1:0] wmask_data,
    output logic [DATA_W-1:0] wvec_data,
    output logic [PAR_W-1:0]  wmask_par,
    output logic [PAR_W-1:0]  wvec_par,
    output logic [DATA_W-1:0] rdata,
    output logic [PAR_W-1:0]  rpar
);

    // Elaboration halts on an out-of-range width.
    if (WRITE_WIDTH < 1 || WRITE_WIDTH > 36 || READ_WIDTH < 1 || READ_WIDTH > 36) begin : g_bad_width
        $error("ram36k_port: width out of range 1..36 (write %0d, read %0d)", WRITE_WIDTH, READ_WIDTH);
    end

    localparam int EW_W = eff_width(WRITE_WIDTH);
    localparam int EW_R = eff_width(READ_WIDTH);

    localparam logic [DATA_W-1:0] WUNIT_D = data_unit_mask(EW_W);
    localparam logic [PAR_W-1:0]  WUNIT_P = par_unit_mask(EW_W);
    localparam logic [DATA_W-1:0] RUNIT_D = data_unit_mask(EW_R);
    localparam logic [PAR_W-1:0]  RUNIT_P = par_unit_mask(EW_R);

    logic [4:0] woff;
    logic [4:0] roff;
    logic [1:0] wpoff;
    logic [1:0] rpoff;

    always_comb begin
        row   = addr[ADDR_W-1:5];
        woff  = data_lane_off(EW_W, addr[4:0]);
        roff  = data_lane_off(EW_R, addr[4:0]);
        wpoff = par_lane_off(EW_W, addr[4:0]);
        rpoff = par_lane_off(EW_R, addr[4:0]);

        // Byte enable i gates byte i of the unit; for widths below 9 the
        // whole unit sits inside byte 0, so be[0] alone gates it.
        wmask_data = (WUNIT_D & byte_expand(be)) << woff;
        wvec_data  = (wdata & WUNIT_D) << woff;
        wmask_par  = (WUNIT_P & be) << wpoff;
        wvec_par   = (wparity & WUNIT_P) << wpoff;

        rdata = (row_data >> roff) & RUNIT_D;
        rpar  = (row_par >> rpoff) & RUNIT_P;
    end

endmodule

// File: rtl/tdp_ram36k_sync.sv
// tdp_ram36k_sync
// Single-clock true-dual-port 36Kb RAM: 1024 rows x (32 data + 4 parity).
//   CLK                 : shared clock, rising edge
//   RESET               : async active-high; clears read registers, blocks writes
//   WEN_x / REN_x       : write / read enable per port
//   BE_x                : byte-write enables
//   ADDR_x              : 15-bit bit-granular address, MSB-aligned
//   WDATA_x / WPARITY_x : write payload
//   RDATA_x / RPARITY_x : registered read data, one-cycle latency, hold when REN=0
// Reads are read-first (old contents, same or other port). When both ports
// write overlapping bits on one edge, port B's bits are stored.
module tdp_ram36k_sync
    import ram36k_pkg::*;
#(
    parameter logic [ROWS*DATA_W-1:0] INIT        = '0,
    parameter logic [ROWS*PAR_W-1:0]  INIT_PARITY = '0,
    parameter int WRITE_WIDTH_A = 36,
    parameter int READ_WIDTH_A  = 36,
    parameter int WRITE_WIDTH_B = 36,
    parameter int READ_WIDTH_B  = 36
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WEN_A,
    input  logic              WEN_B,
    input  logic              REN_A,
    input  logic              REN_B,
    input  logic [PAR_W-1:0]  BE_A,
    input  logic [PAR_W-1:0]  BE_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] WDATA_A,
    input  logic [DATA_W-1:0] WDATA_B,
    input  logic [PAR_W-1:0]  WPARITY_A,
    input  logic [PAR_W-1:0]  WPARITY_B,
    output logic [DATA_W-1:0] RDATA_A,
    output logic [DATA_W-1:0] RDATA_B,
    output logic [PAR_W-1:0]  RPARITY_A,
    output logic [PAR_W-1:0]  RPARITY_B
);

    // Packed [row][bit] layout makes INIT bit k land on row k/32, bit k%32.
    logic [ROWS-1:0][DATA_W-1:0] mem_data_q = INIT;
    logic [ROWS-1:0][PAR_W-1:0]  mem_par_q  = INIT_PARITY;

    logic [ROW_W-1:0]  row_a,        row_b;
    logic [DATA_W-1:0] wmask_data_a, wmask_data_b;
    logic [DATA_W-1:0] wvec_data_a,  wvec_data_b;
    logic [PAR_W-1:0]  wmask_par_a,  wmask_par_b;
    logic [PAR_W-1:0]  wvec_par_a,   wvec_par_b;
    logic [DATA_W-1:0] rd_ext_a,     rd_ext_b;
    logic [PAR_W-1:0]  rp_ext_a,     rp_ext_b;

    logic [DATA_W-1:0] row_a_data_d, row_b_data_d, base_b_data;
    logic [PAR_W-1:0]  row_a_par_d,  row_b_par_d,  base_b_par;

    logic [DATA_W-1:0] rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;
    logic [PAR_W-1:0]  rpar_a_d,  rpar_a_q,  rpar_b_d,  rpar_b_q;

    ram36k_port #(
        .WRITE_WIDTH(WRITE_WIDTH_A),
        .READ_WIDTH (READ_WIDTH_A)
    ) u_port_a (
        .addr      (ADDR_A),
        .be        (BE_A),
        .wdata     (WDATA_A),
        .wparity   (WPARITY_A),
        .row_data  (mem_data_q[row_a]),
        .row_par   (mem_par_q[row_a]),
        .row       (row_a),
        .wmask_data(wmask_data_a),
        .wvec_data (wvec_data_a),
        .wmask_par (wmask_par_a),
        .wvec_par  (wvec_par_a),
        .rdata     (rd_ext_a),
        .rpar      (rp_ext_a)
    );

    ram36k_port #(
        .WRITE_WIDTH(WRITE_WIDTH_B),
        .READ_WIDTH (READ_WIDTH_B)
    ) u_port_b (
        .addr      (ADDR_B),
        .be        (BE_B),
        .wdata     (WDATA_B),
        .wparity   (WPARITY_B),
        .row_data  (mem_data_q[row_b]),
        .row_par   (mem_par_q[row_b]),
        .row       (row_b),
        .wmask_data(wmask_data_b),
        .wvec_data (wvec_data_b),
        .wmask_par (wmask_par_b),
        .wvec_par  (wvec_par_b),
        .rdata     (rd_ext_b),
        .rpar      (rp_ext_b)
    );

    always_comb begin
        row_a_data_d = (mem_data_q[row_a] & ~wmask_data_a) | (wvec_data_a & wmask_data_a);
        row_a_par_d  = (mem_par_q[row_a]  & ~wmask_par_a)  | (wvec_par_a  & wmask_par_a);

        // When both ports write the same row, B merges on top of A's result so
        // A's non-overlapping lanes survive and B wins where they overlap. The
        // row B commits is then a superset of A's, so its later store is safe.
        if (WEN_A && (row_b == row_a)) begin
            base_b_data = row_a_data_d;
            base_b_par  = row_a_par_d;
        end else begin
            base_b_data = mem_data_q[row_b];
            base_b_par  = mem_par_q[row_b];
        end
        row_b_data_d = (base_b_data & ~wmask_data_b) | (wvec_data_b & wmask_data_b);
        row_b_par_d  = (base_b_par  & ~wmask_par_b)  | (wvec_par_b  & wmask_par_b);

        rdata_a_d = REN_A ? rd_ext_a : rdata_a_q;
        rpar_a_d  = REN_A ? rp_ext_a : rpar_a_q;
        rdata_b_d = REN_B ? rd_ext_b : rdata_b_q;
        rpar_b_d  = REN_B ? rp_ext_b : rpar_b_q;
    end

    // Storage is never cleared by reset; reset only suppresses writes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (WEN_A) begin
                mem_data_q[row_a] <= row_a_data_d;
                mem_par_q[row_a]  <= row_a_par_d;
            end
            if (WEN_B) begin
                mem_data_q[row_b] <= row_b_data_d;
                mem_par_q[row_b]  <= row_b_par_d;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdata_a_q <= '0;
            rpar_a_q  <= '0;
            rdata_b_q <= '0;
            rpar_b_q  <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rpar_a_q  <= rpar_a_d;
            rdata_b_q <= rdata_b_d;
            rpar_b_q  <= rpar_b_d;
        end
    end

    assign RDATA_A   = rdata_a_q;
    assign RPARITY_A = rpar_a_q;
    assign RDATA_B   = rdata_b_q;
    assign RPARITY_B = rpar_b_q;

endmodule

// File: tb/tb_tdp_ram36k_sync.sv
// Testbench for tdp_ram36k_sync: three instances with different port widths
// share one stimulus stream; a bit-level array model tracks each instance.
module tb_tdp_ram36k_sync;

    localparam int NI = 3;
    localparam logic [32767:0] TB_INIT     = 32768'({32'h0000AAAA, 64'h0, 32'h11223344});
    localparam logic [4095:0]  TB_INIT_PAR = '0;

    // Instance 1 (mixed) and instance 2 (small) port widths.
    localparam int M_WB = 3;
    localparam int M_RB = 9;
    localparam int S_WA = 17;
    localparam int S_RA = 2;
    localparam int S_WB = 1;
    localparam int S_RB = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen_a, ren_a, wen_b, ren_b;
    logic [3:0]  be_a, be_b, wpar_a, wpar_b;
    logic [14:0] addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;

    logic [31:0] rdata_a [NI];
    logic [31:0] rdata_b [NI];
    logic [3:0]  rpar_a  [NI];
    logic [3:0]  rpar_b  [NI];

    always #5 clk = ~clk;

    tdp_ram36k_sync #(
        .INIT(TB_INIT), .INIT_PARITY(TB_INIT_PAR),
        .WRITE_WIDTH_A(36), .READ_WIDTH_A(36), .WRITE_WIDTH_B(36), .READ_WIDTH_B(36)
    ) u_dut36 (
        .CLK(clk), .RESET(rst),
        .WEN_A(wen_a), .WEN_B(wen_b), .REN_A(ren_a), .REN_B(ren_b),
        .BE_A(be_a), .BE_B(be_b), .ADDR_A(addr_a), .ADDR_B(addr_b),
        .WDATA_A(wdata_a), .WDATA_B(wdata_b), .WPARITY_A(wpar_a), .WPARITY_B(wpar_b),
        .RDATA_A(rdata_a[0]), .RDATA_B(rdata_b[0]), .RPARITY_A(rpar_a[0]), .RPARITY_B(rpar_b[0])
    );

    tdp_ram36k_sync #(
        .INIT(TB_INIT), .INIT_PARITY(TB_INIT_PAR),
        .WRITE_WIDTH_A(36), .READ_WIDTH_A(36), .WRITE_WIDTH_B(M_WB), .READ_WIDTH_B(M_RB)
    ) u_mix (
        .CLK(clk), .RESET(rst),
        .WEN_A(wen_a), .WEN_B(wen_b), .REN_A(ren_a), .REN_B(ren_b),
        .BE_A(be_a), .BE_B(be_b), .ADDR_A(addr_a), .ADDR_B(addr_b),
        .WDATA_A(wdata_a), .WDATA_B(wdata_b), .WPARITY_A(wpar_a), .WPARITY_B(wpar_b),
        .RDATA_A(rdata_a[1]), .RDATA_B(rdata_b[1]), .RPARITY_A(rpar_a[1]), .RPARITY_B(rpar_b[1])
    );

    tdp_ram36k_sync #(
        .INIT(TB_INIT), .INIT_PARITY(TB_INIT_PAR),
        .WRITE_WIDTH_A(S_WA), .READ_WIDTH_A(S_RA), .WRITE_WIDTH_B(S_WB), .READ_WIDTH_B(S_RB)
    ) u_sm (
        .CLK(clk), .RESET(rst),
        .WEN_A(wen_a), .WEN_B(wen_b), .REN_A(ren_a), .REN_B(ren_b),
        .BE_A(be_a), .BE_B(be_b), .ADDR_A(addr_a), .ADDR_B(addr_b),
        .WDATA_A(wdata_a), .WDATA_B(wdata_b), .WPARITY_A(wpar_a), .WPARITY_B(wpar_b),
        .RDATA_A(rdata_a[2]), .RDATA_B(rdata_b[2]), .RPARITY_A(rpar_a[2]), .RPARITY_B(rpar_b[2])
    );

    // ---------------- reference model ----------------
    bit          md [NI][32768];
    bit          mp [NI][4096];
    logic [35:0] eo_a [NI];
    logic [35:0] eo_b [NI];
    int          ew_wa [NI];
    int          ew_ra [NI];
    int          ew_wb [NI];
    int          ew_rb [NI];

    int n_run  = 0;
    int n_fail = 0;

    function automatic int effw(input int w);
        if (w <= 1)  return 1;
        if (w <= 2)  return 2;
        if (w <= 4)  return 4;
        if (w <= 9)  return 9;
        if (w <= 18) return 18;
        return 36;
    endfunction

    // Result packed as {parity[3:0], data[31:0]}, right-aligned.
    function automatic logic [35:0] model_read(input int k, input int ew, input logic [14:0] addr);
        logic [35:0] r;
        int row, first, nb, off;
        r   = '0;
        row = int'(addr[14:5]);
        if (ew >= 9) begin
            nb    = ew / 9;
            first = (ew == 36) ? 0 : (ew == 18) ? 2 * int'(addr[4]) : int'(addr[4:3]);
            for (int j = 0; j < nb; j++) begin
                for (int i = 0; i < 8; i++) r[8*j+i] = md[k][row*32 + 8*(first+j) + i];
                r[32+j] = mp[k][row*4 + first + j];
            end
        end else begin
            off = (int'(addr[4:0]) / ew) * ew;
            for (int i = 0; i < ew; i++) r[i] = md[k][row*32 + off + i];
        end
        return r;
    endfunction

    task automatic model_write(input int k, input int ew, input logic [14:0] addr,
                               input logic [3:0] be, input logic [31:0] wd, input logic [3:0] wp);
        int row, first, nb, off;
        row = int'(addr[14:5]);
        if (ew >= 9) begin
            nb    = ew / 9;
            first = (ew == 36) ? 0 : (ew == 18) ? 2 * int'(addr[4]) : int'(addr[4:3]);
            for (int j = 0; j < nb; j++) begin
                if (be[j]) begin
                    for (int i = 0; i < 8; i++) md[k][row*32 + 8*(first+j) + i] = wd[8*j+i];
                    mp[k][row*4 + first + j] = wp[j];
                end
            end
        end else begin
            off = (int'(addr[4:0]) / ew) * ew;
            if (be[0]) begin
                for (int i = 0; i < ew; i++) md[k][row*32 + off + i] = wd[i];
            end
        end
    endtask

    // One rising edge: all reads see pre-edge contents, then A writes, then B.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                eo_a[k] = '0;
                eo_b[k] = '0;
            end else begin
                if (ren_a) eo_a[k] = model_read(k, ew_ra[k], addr_a);
                if (ren_b) eo_b[k] = model_read(k, ew_rb[k], addr_b);
                if (wen_a) model_write(k, ew_wa[k], addr_a, be_a, wdata_a, wpar_a);
                if (wen_b) model_write(k, ew_wb[k], addr_b, be_b, wdata_b, wpar_b);
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int idx, input logic [35:0] act, input logic [35:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %09h expected %09h", name, idx, act, exp);
        end
    endtask

    function automatic logic [35:0] out_a(input int k);
        return {rpar_a[k], rdata_a[k]};
    endfunction

    function automatic logic [35:0] out_b(input int k);
        return {rpar_b[k], rdata_b[k]};
    endfunction

    task automatic idle();
        wen_a = 1'b0; ren_a = 1'b0; be_a = 4'h0; addr_a = '0; wdata_a = '0; wpar_a = 4'h0;
        wen_b = 1'b0; ren_b = 1'b0; be_b = 4'h0; addr_b = '0; wdata_b = '0; wpar_b = 4'h0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_model_all(input string name, input int idx);
        for (int k = 0; k < NI; k++) begin
            chk({name, "_a"}, idx * NI + k, out_a(k), eo_a[k]);
            chk({name, "_b"}, idx * NI + k, out_b(k), eo_b[k]);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        wa, ra;
        logic [3:0]  bea;
        logic [14:0] ada;
        logic [31:0] wda;
        logic [3:0]  wpa;
        logic        wb, rb;
        logic [3:0]  beb;
        logic [14:0] adb;
        logic [31:0] wdb;
        logic [3:0]  wpb;
        logic [35:0] exp_a;     // port A of the two 36-wide-A instances
        logic [35:0] exp_b36;   // port B of the all-36 instance
        logic [35:0] exp_bmix;  // port B of the mixed instance (read width 9)
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    logic [32767:0] init_v;
    logic [4095:0]  init_p;

    initial begin
        init_v = TB_INIT;
        init_p = TB_INIT_PAR;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 32768; i++) md[k][i] = init_v[i];
            for (int i = 0; i < 4096; i++)  mp[k][i] = init_p[i];
            eo_a[k] = '0;
            eo_b[k] = '0;
        end
        ew_wa[0] = effw(36);   ew_ra[0] = effw(36);   ew_wb[0] = effw(36);   ew_rb[0] = effw(36);
        ew_wa[1] = effw(36);   ew_ra[1] = effw(36);   ew_wb[1] = effw(M_WB); ew_rb[1] = effw(M_RB);
        ew_wa[2] = effw(S_WA); ew_ra[2] = effw(S_RA); ew_wb[2] = effw(S_WB); ew_rb[2] = effw(S_RB);

        //          wa    ra    bea   ada       wda           wpa   wb    rb    beb   adb       wdb          wpb   exp_a          exp_b36        exp_bmix
        vt[0]  = '{1'b1, 1'b0, 4'hF, 15'h0020, 32'hDEADBEEF, 4'hA, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h000000000, 36'h000000000, 36'h000000000};
        vt[1]  = '{1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,        4'h0, 1'b0, 1'b1, 4'h0, 15'h0020, 32'h0,       4'h0, 36'h000000000, 36'hADEADBEEF, 36'h0000000EF};
        vt[2]  = '{1'b1, 1'b0, 4'hF, 15'h0020, 32'h87654321, 4'h5, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h000000000, 36'hADEADBEEF, 36'h0000000EF};
        vt[3]  = '{1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,        4'h0, 1'b0, 1'b1, 4'h0, 15'h0020, 32'h0,       4'h0, 36'h000000000, 36'h587654321, 36'h100000021};
        vt[4]  = '{1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,        4'h0, 1'b0, 1'b1, 4'h0, 15'h0038, 32'h0,       4'h0, 36'h000000000, 36'h587654321, 36'h000000087};
        vt[5]  = '{1'b1, 1'b0, 4'h5, 15'h0000, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h000000000, 36'h587654321, 36'h000000087};
        vt[6]  = '{1'b0, 1'b1, 4'h0, 15'h0000, 32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h011FF33FF, 36'h587654321, 36'h000000087};
        vt[7]  = '{1'b1, 1'b1, 4'hF, 15'h0060, 32'h00005555, 4'h0, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h00000AAAA, 36'h587654321, 36'h000000087};
        vt[8]  = '{1'b0, 1'b1, 4'h0, 15'h0060, 32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h000005555, 36'h587654321, 36'h000000087};
        vt[9]  = '{1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h000005555, 36'h587654321, 36'h000000087};
        vt[10] = vt[9];
        vt[11] = vt[9];
        vt[12] = '{1'b1, 1'b0, 4'hF, 15'h0040, 32'h00000001, 4'h0, 1'b1, 1'b0, 4'hF, 15'h0040, 32'h2,       4'h0, 36'h000005555, 36'h587654321, 36'h000000087};
        vt[13] = '{1'b0, 1'b1, 4'h0, 15'h0040, 32'h0,        4'h0, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,       4'h0, 36'h000000002, 36'h587654321, 36'h000000087};
        vt[14] = '{1'b1, 1'b0, 4'hF, 15'h0020, 32'hCAFEF00D, 4'h3, 1'b0, 1'b1, 4'h0, 15'h0020, 32'h0,       4'h0, 36'h000000002, 36'h587654321, 36'h100000021};
        vt[15] = '{1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,        4'h0, 1'b0, 1'b1, 4'h0, 15'h0020, 32'h0,       4'h0, 36'h000000002, 36'h3CAFEF00D, 36'h10000000D};

        // Reset state
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_a", k, out_a(k), 36'h0);
            chk("reset_b", k, out_b(k), 36'h0);
        end
        rst = 1'b0;

        // Directed table
        for (int v = 0; v < NV; v++) begin
            wen_a = vt[v].wa; ren_a = vt[v].ra; be_a = vt[v].bea; addr_a = vt[v].ada;
            wdata_a = vt[v].wda; wpar_a = vt[v].wpa;
            wen_b = vt[v].wb; ren_b = vt[v].rb; be_b = vt[v].beb; addr_b = vt[v].adb;
            wdata_b = vt[v].wdb; wpar_b = vt[v].wpb;
            step();
            chk("dir_a36",  v, out_a(0), vt[v].exp_a);
            chk("dir_amix", v, out_a(1), vt[v].exp_a);
            chk("dir_b36",  v, out_b(0), vt[v].exp_b36);
            chk("dir_bmix", v, out_b(1), vt[v].exp_bmix);
        end

        // Reset asserted between edges: outputs clear at once
        idle();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            eo_a[k] = '0;
            eo_b[k] = '0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("async_rst_a", k, out_a(k), 36'h0);
            chk("async_rst_b", k, out_b(k), 36'h0);
        end
        // A write attempted under reset must not land
        wen_a = 1'b1; be_a = 4'hF; addr_a = 15'h0020; wdata_a = 32'h0; wpar_a = 4'h0;
        step();
        chk_model_all("rst_hold", 0);
        // First edge after release reads the untouched row
        rst = 1'b0;
        idle();
        ren_a = 1'b1; addr_a = 15'h0020;
        ren_b = 1'b1; addr_b = 15'h0020;
        step();
        chk("post_rst_a36",  0, out_a(0), 36'h3CAFEF00D);
        chk("post_rst_amix", 0, out_a(1), 36'h3CAFEF00D);
        chk("post_rst_b36",  0, out_b(0), 36'h3CAFEF00D);
        chk("post_rst_bmix", 0, out_b(1), 36'h10000000D);
        chk_model_all("post_rst", 0);

        // Randomized traffic on a few rows so collisions are frequent
        for (int c = 0; c < 800; c++) begin
            rst     = ($urandom_range(0, 63) == 0);
            wen_a   = 1'($urandom);
            ren_a   = 1'($urandom);
            be_a    = 4'($urandom);
            addr_a  = 15'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            wdata_a = $urandom;
            wpar_a  = 4'($urandom);
            wen_b   = 1'($urandom);
            ren_b   = 1'($urandom);
            be_b    = 4'($urandom);
            addr_b  = 15'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            wdata_b = $urandom;
            wpar_b  = 4'($urandom);
            if (rst) begin
                for (int k = 0; k < NI; k++) begin
                    eo_a[k] = '0;
                    eo_b[k] = '0;
                end
            end
            step();
            chk_model_all("rand", c);
        end

        rst = 1'b0;
        idle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
